// File: rtl/shreg256_ctrl.sv
// Sequencer for a WORDS x DW circular shift chain: word-serial load, non-destructive unload,
// rotate by N words and clear. Define SHREG_CTRL_CLR_EN to build the CLR state for op 11.
module shreg256_ctrl #(
  parameter int unsigned WORDS = 8,
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_amt,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          sr_we,
  output logic [DW-1:0] sr_din,
  input  logic [DW-1:0] sr_dout,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [AW-1:0] LastCnt  = AW'(WORDS - 1);
  localparam logic [1:0]    OpLoad   = 2'b00;
  localparam logic [1:0]    OpUnload = 2'b01;
  localparam logic [1:0]    OpRotate = 2'b10;
  localparam logic [1:0]    OpClear  = 2'b11;

`ifdef SHREG_CTRL_CLR_EN
  typedef enum logic [2:0] {StIdle, StLoad, StUnload, StRot, StClr} state_e;
`else
  typedef enum logic [2:0] {StIdle, StLoad, StUnload, StRot} state_e;
`endif

  state_e        r_state, w_state_d;
  logic [AW-1:0] r_cnt, w_cnt_d;
  logic [AW-1:0] r_amt, w_amt_d;
  logic          r_done, w_done_d;
  logic          r_err, w_err_d;
  logic [AW-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + AW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_amt   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_amt   <= w_amt_d;
      r_done  <= w_done_d;
      r_err   <= w_err_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_amt_d   = r_amt;
    w_done_d  = 1'b0;
    w_err_d   = 1'b0;
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    sr_we     = 1'b0;
    sr_din    = '0;

    case (r_state)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_cnt_d = '0;
          w_amt_d = cmd_amt;
          unique case (cmd_op)
            OpLoad:   w_state_d = StLoad;
            OpUnload: w_state_d = StUnload;
            OpRotate: begin
              // Zero-word rotate completes without ever leaving IDLE.
              if (cmd_amt == '0) w_done_d  = 1'b1;
              else               w_state_d = StRot;
            end
            OpClear: begin
`ifdef SHREG_CTRL_CLR_EN
              w_state_d = StClr;
`else
              w_done_d = 1'b1;
              w_err_d  = 1'b1;
`endif
            end
          endcase
        end
      end

      StLoad: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sr_we   = 1'b1;
          sr_din  = in_data;
          w_cnt_d = w_cnt_inc;
          if (r_cnt == LastCnt) begin
            w_state_d = StIdle;
            w_done_d  = 1'b1;
          end
        end
      end

      StUnload: begin
        out_valid = 1'b1;
        out_data  = sr_dout;
        // Recirculating the tail keeps the chain intact after WORDS transfers.
        if (out_ready) begin
          sr_we   = 1'b1;
          sr_din  = sr_dout;
          w_cnt_d = w_cnt_inc;
          if (r_cnt == LastCnt) begin
            w_state_d = StIdle;
            w_done_d  = 1'b1;
          end
        end
      end

      StRot: begin
        sr_we   = 1'b1;
        sr_din  = sr_dout;
        w_cnt_d = w_cnt_inc;
        if (w_cnt_inc == r_amt) begin
          w_state_d = StIdle;
          w_done_d  = 1'b1;
        end
      end

`ifdef SHREG_CTRL_CLR_EN
      StClr: begin
        sr_we   = 1'b1;
        w_cnt_d = w_cnt_inc;
        if (r_cnt == LastCnt) begin
          w_state_d = StIdle;
          w_done_d  = 1'b1;
        end
      end
`endif

      default: w_state_d = StIdle;
    endcase
  end

  assign busy = (r_state != StIdle);
  assign done = r_done;
  assign err  = r_err;

endmodule

// File: tb/tb_shreg256_ctrl.sv
// Directed self-checking bench for shreg256_ctrl, with a behavioural 8 x 32-bit chain attached.
module tb_shreg256_ctrl;

  localparam int AW = 3;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_amt;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic          sr_we;
  logic [31:0]   sr_din;
  logic [31:0]   sr_dout;
  logic          busy;
  logic          done;
  logic          err;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] chain [8];
  logic [31:0] we_log [$];
  logic [31:0] orig [8];
  logic [31:0] rot3 [8];
  logic [31:0] zeros [8];

  shreg256_ctrl #(.WORDS(8), .DW(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_amt   (cmd_amt),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sr_we     (sr_we),
    .sr_din    (sr_din),
    .sr_dout   (sr_dout),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sr_we) begin
      for (int i = 7; i > 0; i--) chain[i] <= chain[i-1];
      chain[0] <= sr_din;
      we_log.push_back(sr_din);
    end
  end
  assign sr_dout = chain[7];

  // Assumes the caller sits on a negedge; returns on the negedge after the accept edge.
  task automatic issue_cmd(input logic [1:0] op, input logic [AW-1:0] amt);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_amt   = amt;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic load_beats(output int cyc);
    int k = 0;
    cyc = 0;
    while (k < 8 && cyc < 200) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = orig[k];
      @(negedge clk);
      if (in_valid) k++;
      cyc++;
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_checks++;
    if ({cmd_ready, busy, in_ready, out_valid, sr_we, done, err} !== 7'b1000000 || sr_din !== 0) begin
      n_errors++;
      $display("FAIL reset_outputs got rdy=%b busy=%b ir=%b ov=%b we=%b din=%h done=%b err=%b",
               cmd_ready, busy, in_ready, out_valid, sr_we, sr_din, done, err);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_errors++;
      $display("FAIL post_reset_idle got rdy=%b busy=%b done=%b want 1 0 0", cmd_ready, busy, done);
    end
  endtask

  task automatic test_load();
    int cyc;
    we_log.delete();
    issue_cmd(2'b00, '0);
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL load_state got ir=%b busy=%b rdy=%b want 1 1 0", in_ready, busy, cmd_ready);
    end
    load_beats(cyc);
    n_checks++;
    if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL load_done got done=%b err=%b busy=%b want 1 0 0", done, err, busy);
    end
    n_checks++;
    if (we_log.size() != 8) begin
      n_errors++;
      $display("FAIL load_we_count got %0d want 8", we_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (we_log[i] !== orig[i]) begin
          n_errors++;
          $display("FAIL load_word%0d got %h want %h", i, we_log[i], orig[i]);
        end
      end
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin
      n_errors++;
      $display("FAIL load_done_pulse got %b want 0", done);
    end
  endtask

  task automatic test_unload(input logic [31:0] exp [8], input string name);
    int  k = 0;
    int  cyc = 0;
    bit  bad_valid = 0;
    we_log.delete();
    issue_cmd(2'b01, '0);
    while (k < 8 && cyc < 200) begin
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (out_valid !== 1'b1) bad_valid = 1;
      if (out_ready) begin
        n_checks++;
        if (out_data !== exp[k]) begin
          n_errors++;
          $display("FAIL %s_word%0d got %h want %h", name, k, out_data, exp[k]);
        end
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    n_checks++;
    if (bad_valid || k != 8) begin
      n_errors++;
      $display("FAIL %s_stream got words=%0d valid_drop=%0d want 8 0", name, k, bad_valid);
    end
    n_checks++;
    if (done !== 1'b1 || out_valid !== 1'b0 || we_log.size() != 8) begin
      n_errors++;
      $display("FAIL %s_done got done=%b ov=%b we=%0d want 1 0 8", name, done, out_valid,
               we_log.size());
    end
  endtask

  task automatic test_rotate(input logic [AW-1:0] amt);
    int cyc = 0;
    int nwe = 0;
    we_log.delete();
    issue_cmd(2'b10, amt);
    while (done !== 1'b1 && cyc < 20) begin
      if (sr_we === 1'b1) nwe++;
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc != int'(amt) || nwe != int'(amt) || we_log.size() != int'(amt) || err !== 1'b0) begin
      n_errors++;
      $display("FAIL rotate%0d got cycles=%0d we=%0d shifts=%0d err=%b want %0d %0d %0d 0",
               amt, cyc, nwe, we_log.size(), err, amt, amt, amt);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [3:0] busy_seq;
    issue_cmd(2'b10, 3'd2);
    busy_seq[0] = busy;
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_amt   = '0;
    @(negedge clk);
    busy_seq[1] = busy;
    @(negedge clk);
    busy_seq[2] = busy;
    n_checks++;
    if (done !== 1'b1 || cmd_ready !== 1'b1 || we_log.size() != 2) begin
      n_errors++;
      $display("FAIL b2b_done_cycle got done=%b rdy=%b shifts=%0d want 1 1 2", done, cmd_ready,
               we_log.size());
    end
    we_log.delete();
    @(negedge clk);
    cmd_valid   = 1'b0;
    busy_seq[3] = busy;
    n_checks++;
    if (busy_seq !== 4'b1011 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_busy got busy=%b ir=%b want 1011 1", busy_seq, in_ready);
    end
    load_beats(cyc);
    n_checks++;
    if (done !== 1'b1 || we_log.size() != 8 || we_log[0] !== orig[0] || we_log[7] !== orig[7]) begin
      n_errors++;
      $display("FAIL b2b_load got done=%b shifts=%0d want 1 8", done, we_log.size());
    end
    @(negedge clk);
  endtask

  task automatic test_clear();
    int cyc = 0;
    int nz  = 0;
    we_log.delete();
    issue_cmd(2'b11, '0);
`ifdef SHREG_CTRL_CLR_EN
    while (done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    foreach (we_log[i]) if (we_log[i] !== 32'h0) nz++;
    n_checks++;
    if (cyc != 8 || we_log.size() != 8 || nz != 0 || err !== 1'b0) begin
      n_errors++;
      $display("FAIL clear got cycles=%0d shifts=%0d nonzero=%0d err=%b want 8 8 0 0", cyc,
               we_log.size(), nz, err);
    end
    test_unload(zeros, "unload_clr");
`else
    n_checks++;
    if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b0 || we_log.size() != 0) begin
      n_errors++;
      $display("FAIL clear_unsupported got done=%b err=%b busy=%b shifts=%0d want 1 1 0 0", done,
               err, busy, we_log.size());
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || err !== 1'b0 || we_log.size() != 0) begin
      n_errors++;
      $display("FAIL clear_pulse got done=%b err=%b shifts=%0d want 0 0 0", done, err,
               we_log.size());
    end
`endif
  endtask

  task automatic test_reset_mid_load();
    bit done_seen = 0;
    issue_cmd(2'b00, '0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = orig[i];
      @(negedge clk);
    end
    in_data = orig[3];
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cmd_ready, busy, in_ready, sr_we, done, err} !== 6'b100000 || sr_din !== 0) begin
      n_errors++;
      $display("FAIL reset_mid_load got rdy=%b busy=%b ir=%b we=%b din=%h done=%b err=%b",
               cmd_ready, busy, in_ready, sr_we, sr_din, done, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) done_seen = 1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (done_seen) begin
      n_errors++;
      $display("FAIL reset_abort got done/ir/busy activity=1 want 0");
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_amt   = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      orig[i]  = 32'h1111_1111 * (i + 1);
      rot3[i]  = 32'h1111_1111 * (((i + 3) % 8) + 1);
      zeros[i] = 32'h0;
    end

    test_reset();
    test_load();
    test_unload(orig, "unload1");
    test_unload(orig, "unload2");
    test_rotate(3'd3);
    test_unload(rot3, "unload_rot3");
    test_rotate(3'd0);
    test_back_to_back();
    test_unload(orig, "unload_b2b");
    test_clear();
    test_reset_mid_load();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
